// File: rtl/mc_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mc_pkg                                                             |
// | Shared states, opcode constants, datapath codes and output decode. |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
package mc_pkg;

   typedef enum logic [3:0] {
      ST_IDLE    = 4'd0,
      ST_FETCH   = 4'd1,
      ST_DECODE  = 4'd2,
      ST_MEMADDR = 4'd3,
      ST_MEMRD   = 4'd4,
      ST_MEMWB   = 4'd5,
      ST_MEMWR   = 4'd6,
      ST_EXEC_R  = 4'd7,
      ST_EXEC_I  = 4'd8,
      ST_RWB     = 4'd9,
      ST_BRANCH  = 4'd10,
      ST_JUMP    = 4'd11,
      ST_JAL     = 4'd12,
      ST_JR      = 4'd13
   } state_t;

   localparam logic [5:0] C_OP_RTYPE  = 6'b000000;
   localparam logic [5:0] C_OP_REGIMM = 6'b000001;
   localparam logic [5:0] C_OP_J      = 6'b000010;
   localparam logic [5:0] C_OP_JAL    = 6'b000011;
   localparam logic [5:0] C_OP_BEQ    = 6'b000100;
   localparam logic [5:0] C_OP_ADDI   = 6'b001000;
   localparam logic [5:0] C_OP_LW     = 6'b100011;
   localparam logic [5:0] C_OP_SW     = 6'b101011;
   localparam logic [5:0] C_FUNCT_JR  = 6'b001000;

   localparam logic [1:0] C_ALUSRCB_REG   = 2'b00;
   localparam logic [1:0] C_ALUSRCB_FOUR  = 2'b01;
   localparam logic [1:0] C_ALUSRCB_IMM   = 2'b10;
   localparam logic [1:0] C_ALUSRCB_SHIMM = 2'b11;

   localparam logic [1:0] C_ALUOP_ADD    = 2'b00;
   localparam logic [1:0] C_ALUOP_SUB    = 2'b01;
   localparam logic [1:0] C_ALUOP_FUNCT  = 2'b10;
   localparam logic [1:0] C_ALUOP_REGIMM = 2'b11;

   localparam logic [1:0] C_PCSRC_ALU    = 2'b00;
   localparam logic [1:0] C_PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] C_PCSRC_JUMP   = 2'b10;
   localparam logic [1:0] C_PCSRC_REG    = 2'b11;

   typedef struct packed {
      logic       irwrite;
      logic       pcwrite;
      logic       pcwritecond;
      logic       iord;
      logic       memread;
      logic       memwrite;
      logic       regwrite;
      logic       regdst;
      logic       memtoreg;
      logic       jal_sel;
      logic       alusrca;
      logic [1:0] alusrcb;
      logic [1:0] aluop;
      logic [1:0] pcsource;
   } ctl_t;

   // FETCH sets irwrite/pcwrite as "armed"; the top qualifies them with mem_ready.
   function automatic ctl_t decode_ctl(input state_t st, input logic is_regimm,
                                       input logic rwb_regdst);
      ctl_t c;
      c = '0;
      case (st)
         ST_FETCH: begin
            c.memread = 1'b1;
            c.irwrite = 1'b1;
            c.pcwrite = 1'b1;
            c.alusrcb = C_ALUSRCB_FOUR;
            c.aluop   = C_ALUOP_ADD;
            c.pcsource = C_PCSRC_ALU;
         end
         ST_DECODE: begin
            c.alusrcb = C_ALUSRCB_SHIMM;
            c.aluop   = C_ALUOP_ADD;
         end
         ST_MEMADDR, ST_EXEC_I: begin
            c.alusrca = 1'b1;
            c.alusrcb = C_ALUSRCB_IMM;
            c.aluop   = C_ALUOP_ADD;
         end
         ST_MEMRD: begin
            c.memread = 1'b1;
            c.iord    = 1'b1;
         end
         ST_MEMWB: begin
            c.regwrite = 1'b1;
            c.memtoreg = 1'b1;
         end
         ST_MEMWR: begin
            c.memwrite = 1'b1;
            c.iord     = 1'b1;
         end
         ST_EXEC_R: begin
            c.alusrca = 1'b1;
            c.alusrcb = C_ALUSRCB_REG;
            c.aluop   = C_ALUOP_FUNCT;
         end
         ST_RWB: begin
            c.regwrite = 1'b1;
            c.regdst   = rwb_regdst;
         end
         ST_BRANCH: begin
            c.alusrca     = 1'b1;
            c.alusrcb     = C_ALUSRCB_REG;
            c.aluop       = is_regimm ? C_ALUOP_REGIMM : C_ALUOP_SUB;
            c.pcwritecond = 1'b1;
            c.pcsource    = C_PCSRC_ALUOUT;
         end
         ST_JUMP: begin
            c.pcwrite  = 1'b1;
            c.pcsource = C_PCSRC_JUMP;
         end
         ST_JAL: begin
            c.pcwrite  = 1'b1;
            c.pcsource = C_PCSRC_JUMP;
            c.regwrite = 1'b1;
            c.jal_sel  = 1'b1;
         end
         ST_JR: begin
            c.pcwrite  = 1'b1;
            c.pcsource = C_PCSRC_REG;
         end
         default: c = '0;
      endcase
      return c;
   endfunction

endpackage
`default_nettype wire

// File: rtl/mc_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mc_if                                                              |
// | Instruction/memory inputs and datapath control outputs.            |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
interface mc_if;
   logic [5:0]  opcode;
   logic [5:0]  funct;
   logic        mem_ready;
   logic        irwrite;
   logic        pcwrite;
   logic        pcwritecond;
   logic        iord;
   logic        memread;
   logic        memwrite;
   logic        regwrite;
   logic        regdst;
   logic        memtoreg;
   logic        jal_sel;
   logic        alusrca;
   logic [1:0]  alusrcb;
   logic [1:0]  aluop;
   logic [1:0]  pcsource;
   logic [3:0]  state;
   logic        illegal;
   logic [15:0] instr_count;

   modport slave (
      input  opcode, funct, mem_ready,
      output irwrite, pcwrite, pcwritecond, iord, memread, memwrite, regwrite,
             regdst, memtoreg, jal_sel, alusrca, alusrcb, aluop, pcsource,
             state, illegal, instr_count
   );

   modport master (
      output opcode, funct, mem_ready,
      input  irwrite, pcwrite, pcwritecond, iord, memread, memwrite, regwrite,
             regdst, memtoreg, jal_sel, alusrca, alusrcb, aluop, pcsource,
             state, illegal, instr_count
   );
endinterface
`default_nettype wire

// File: rtl/mc_dispatch.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mc_dispatch                                                        |
// | Combinational opcode/funct dispatch out of DECODE.                 |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module mc_dispatch
   import mc_pkg::*;
(
   input  logic [5:0] i_opcode,
   input  logic [5:0] i_funct,
   output state_t     o_next_state,
   output logic       o_illegal
);

   always_comb begin
      o_next_state = ST_FETCH;
      o_illegal    = 1'b0;
      case (i_opcode)
         C_OP_RTYPE:        o_next_state = (i_funct == C_FUNCT_JR) ? ST_JR : ST_EXEC_R;
         C_OP_LW, C_OP_SW:  o_next_state = ST_MEMADDR;
         C_OP_ADDI:         o_next_state = ST_EXEC_I;
         C_OP_BEQ,
         C_OP_REGIMM:       o_next_state = ST_BRANCH;
         C_OP_J:            o_next_state = ST_JUMP;
         C_OP_JAL:          o_next_state = ST_JAL;
         default:           o_illegal    = 1'b1;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/multicycle_control.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | multicycle_control                                                 |
// | Multicycle CPU control FSM with retired-instruction counter.       |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module multicycle_control
   import mc_pkg::*;
(
   input  logic clk,
   input  logic rst_n,
   mc_if.slave  bus
);

   state_t      r_state;
   state_t      w_next_state;
   state_t      w_dispatch_state;
   logic        w_dispatch_illegal;
   ctl_t        r_ctl;
   logic        r_rwb_regdst;
   logic        w_rwb_regdst;
   logic        r_illegal;
   logic [15:0] r_instr_count;
   logic        w_retire;

   mc_dispatch u_dispatch (
      .i_opcode     (bus.opcode),
      .i_funct      (bus.funct),
      .o_next_state (w_dispatch_state),
      .o_illegal    (w_dispatch_illegal)
   );

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         ST_IDLE:    w_next_state = ST_FETCH;
         ST_FETCH:   if (bus.mem_ready) w_next_state = ST_DECODE;
         ST_DECODE:  w_next_state = w_dispatch_state;
         ST_MEMADDR: w_next_state = (bus.opcode == C_OP_LW) ? ST_MEMRD : ST_MEMWR;
         ST_MEMRD:   if (bus.mem_ready) w_next_state = ST_MEMWB;
         ST_MEMWR:   if (bus.mem_ready) w_next_state = ST_FETCH;
         ST_EXEC_R,
         ST_EXEC_I:  w_next_state = ST_RWB;
         ST_MEMWB, ST_RWB, ST_BRANCH,
         ST_JUMP, ST_JAL, ST_JR: w_next_state = ST_FETCH;
         default:    w_next_state = ST_IDLE;
      endcase
   end

   // The regdst flag is captured on entry to RWB so the write-back knows its source.
   assign w_rwb_regdst = (w_next_state == ST_RWB) ? (r_state == ST_EXEC_R) : r_rwb_regdst;

   // DECODE only returns to FETCH on the illegal path, which does not retire.
   assign w_retire = (w_next_state == ST_FETCH) && (r_state != ST_FETCH) &&
                     (r_state != ST_IDLE) && (r_state != ST_DECODE);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state       <= ST_IDLE;
         r_ctl         <= '0;
         r_rwb_regdst  <= 1'b0;
         r_illegal     <= 1'b0;
         r_instr_count <= '0;
      end else begin
         r_state      <= w_next_state;
         r_ctl        <= decode_ctl(w_next_state, bus.opcode == C_OP_REGIMM, w_rwb_regdst);
         r_rwb_regdst <= w_rwb_regdst;
         r_illegal    <= (r_state == ST_DECODE) && w_dispatch_illegal;
         if (w_retire) begin
            r_instr_count <= r_instr_count + 16'd1;
         end
      end
   end

   // Instruction fetch writes IR and PC only in the cycle memory delivers the word.
   assign bus.irwrite     = r_ctl.irwrite & bus.mem_ready;
   assign bus.pcwrite     = r_ctl.pcwrite & (bus.mem_ready | (r_state != ST_FETCH));
   assign bus.pcwritecond = r_ctl.pcwritecond;
   assign bus.iord        = r_ctl.iord;
   assign bus.memread     = r_ctl.memread;
   assign bus.memwrite    = r_ctl.memwrite;
   assign bus.regwrite    = r_ctl.regwrite;
   assign bus.regdst      = r_ctl.regdst;
   assign bus.memtoreg    = r_ctl.memtoreg;
   assign bus.jal_sel     = r_ctl.jal_sel;
   assign bus.alusrca     = r_ctl.alusrca;
   assign bus.alusrcb     = r_ctl.alusrcb;
   assign bus.aluop       = r_ctl.aluop;
   assign bus.pcsource    = r_ctl.pcsource;
   assign bus.state       = r_state;
   assign bus.illegal     = r_illegal;
   assign bus.instr_count = r_instr_count;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_multicycle_control                                              |
// | Directed self-checking bench for multicycle_control.               |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module tb_multicycle_control;

   localparam int S_IDLE = 0, S_FETCH = 1, S_DECODE = 2, S_MEMADDR = 3, S_MEMRD = 4;
   localparam int S_MEMWB = 5, S_MEMWR = 6, S_EXEC_R = 7, S_EXEC_I = 8, S_RWB = 9;
   localparam int S_BRANCH = 10, S_JUMP = 11, S_JAL = 12, S_JR = 13;

   typedef struct packed {
      logic [3:0] st;
      logic [1:0] alusrcb;
      logic [1:0] aluop;
      logic [1:0] pcsource;
      logic       alusrca;
      logic       regwrite;
      logic       regdst;
      logic       memtoreg;
      logic       memwrite;
      logic       jal_sel;
      logic       pcwrite;
      logic       pcwritecond;
      logic       illegal;
   } snap_t;

   logic  clk = 1'b0;
   logic  rst_n;
   int    checks = 0;
   int    errors = 0;
   snap_t sn [8];
   int    lw_st  [7] = '{S_DECODE, S_MEMADDR, S_MEMRD, S_MEMRD, S_MEMRD, S_MEMWB, S_FETCH};
   logic  lw_rdy [7] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

   mc_if bus ();

   multicycle_control dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [9:0] strobes();
      return {bus.irwrite, bus.pcwrite, bus.pcwritecond, bus.iord, bus.memread,
              bus.memwrite, bus.regwrite, bus.regdst, bus.memtoreg, bus.jal_sel};
   endfunction

   task automatic snap(input int n);
      sn[n] = '{st: bus.state, alusrcb: bus.alusrcb, aluop: bus.aluop,
                pcsource: bus.pcsource, alusrca: bus.alusrca, regwrite: bus.regwrite,
                regdst: bus.regdst, memtoreg: bus.memtoreg, memwrite: bus.memwrite,
                jal_sel: bus.jal_sel, pcwrite: bus.pcwrite,
                pcwritecond: bus.pcwritecond, illegal: bus.illegal};
   endtask

   // Starts in FETCH at a negedge; runs until FETCH is seen again.
   task automatic run_instr(input string tag, input logic [5:0] op, input logic [5:0] fn,
                            input int exp_cyc);
      int n;
      bus.opcode    = op;
      bus.funct     = fn;
      bus.mem_ready = 1'b1;
      n = 0;
      snap(0);
      do begin
         @(negedge clk);
         n++;
         if (n < 8) snap(n);
      end while (bus.state !== 4'(S_FETCH) && n < 32);
      check({tag, "_cycles"}, n, exp_cyc);
   endtask

   initial begin
      rst_n         = 1'b0;
      bus.opcode    = 6'b000000;
      bus.funct     = 6'b100000;
      bus.mem_ready = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_state", bus.state, S_IDLE);
      check("rst_count", bus.instr_count, 16'h0000);
      check("rst_strobes", strobes(), 10'h000);
      check("rst_illegal", bus.illegal, 1'b0);

      rst_n = 1'b1;
      check("rel_idle", bus.state, S_IDLE);
      @(negedge clk);
      check("rel_fetch", bus.state, S_FETCH);
      check("fetch_ctl", {bus.memread, bus.iord, bus.alusrca, bus.alusrcb, bus.aluop,
                          bus.pcsource, bus.irwrite, bus.pcwrite}, 11'b1_0_0_01_00_00_1_1);

      run_instr("rtype", 6'b000000, 6'b100000, 4);
      check("rtype_decode", {sn[1].st, sn[1].alusrca, sn[1].alusrcb}, {4'(S_DECODE), 3'b0_11});
      check("rtype_exec", {sn[2].st, sn[2].alusrca, sn[2].alusrcb, sn[2].aluop},
            {4'(S_EXEC_R), 5'b1_00_10});
      check("rtype_rwb", {sn[3].st, sn[3].regwrite, sn[3].regdst, sn[3].memtoreg},
            {4'(S_RWB), 3'b110});
      check("rtype_count", bus.instr_count, 16'd1);

      bus.mem_ready = 1'b0;
      #1;
      check("fetch_gate", {bus.irwrite, bus.pcwrite}, 2'b00);
      @(negedge clk);
      check("fetch_hold", bus.state, S_FETCH);

      bus.opcode    = 6'b100011;
      bus.mem_ready = 1'b1;
      for (int k = 0; k < 7; k++) begin
         @(negedge clk);
         check($sformatf("lw_st%0d", k), bus.state, lw_st[k]);
         check($sformatf("lw_wb%0d", k), {bus.memtoreg, bus.regwrite}, (k == 5) ? 2'b11 : 2'b00);
         if (k == 2) check("lw_memrd", {bus.memread, bus.iord}, 2'b11);
         bus.mem_ready = lw_rdy[k];
      end
      check("lw_count", bus.instr_count, 16'd2);

      bus.opcode = 6'b101011;
      @(negedge clk);
      check("sw_decode", bus.state, S_DECODE);
      @(negedge clk);
      check("sw_memaddr", bus.state, S_MEMADDR);
      bus.mem_ready = 1'b0;
      @(negedge clk);
      check("sw_memwr", {bus.state, bus.memwrite, bus.iord}, {4'(S_MEMWR), 2'b11});
      @(negedge clk);
      check("sw_hold", {bus.state, bus.memwrite}, {4'(S_MEMWR), 1'b1});
      check("sw_count", bus.instr_count, 16'd2);
      rst_n = 1'b0;
      @(negedge clk);
      check("midrst_state", bus.state, S_IDLE);
      check("midrst_memwrite", bus.memwrite, 1'b0);
      check("midrst_count", bus.instr_count, 16'd0);
      check("midrst_strobes", strobes(), 10'h000);
      rst_n         = 1'b1;
      bus.mem_ready = 1'b1;
      @(negedge clk);
      check("midrst_fetch", bus.state, S_FETCH);

      run_instr("j", 6'b000010, 6'b000000, 3);
      check("j_exec", {sn[2].st, sn[2].pcsource, sn[2].pcwrite}, {4'(S_JUMP), 3'b10_1});
      check("j_jalsel", {sn[0].jal_sel, sn[1].jal_sel, sn[2].jal_sel}, 3'b000);
      run_instr("jal", 6'b000011, 6'b000000, 3);
      check("jal_exec", {sn[2].st, sn[2].pcsource, sn[2].pcwrite, sn[2].regwrite},
            {4'(S_JAL), 4'b10_1_1});
      check("jal_jalsel", {sn[0].jal_sel, sn[1].jal_sel, sn[2].jal_sel}, 3'b001);
      run_instr("jr", 6'b000000, 6'b001000, 3);
      check("jr_exec", {sn[2].st, sn[2].pcsource, sn[2].pcwrite}, {4'(S_JR), 3'b11_1});
      check("jr_jalsel", {sn[0].jal_sel, sn[1].jal_sel, sn[2].jal_sel}, 3'b000);
      check("jumps_count", bus.instr_count, 16'd3);

      run_instr("addi", 6'b001000, 6'b000000, 4);
      check("addi_exec", {sn[2].st, sn[2].alusrca, sn[2].alusrcb, sn[2].aluop},
            {4'(S_EXEC_I), 5'b1_10_00});
      check("addi_rwb", {sn[3].st, sn[3].regwrite, sn[3].regdst}, {4'(S_RWB), 2'b10});
      run_instr("sw", 6'b101011, 6'b000000, 4);
      check("sw_wr", {sn[3].st, sn[3].memwrite}, {4'(S_MEMWR), 1'b1});
      run_instr("beq", 6'b000100, 6'b000000, 3);
      check("beq_exec", {sn[2].st, sn[2].alusrca, sn[2].alusrcb, sn[2].aluop,
                         sn[2].pcwritecond, sn[2].pcsource}, {4'(S_BRANCH), 8'b1_00_01_1_01});
      run_instr("bgez", 6'b000001, 6'b000000, 3);
      check("bgez_exec", {sn[2].st, sn[2].aluop, sn[2].pcwritecond}, {4'(S_BRANCH), 3'b11_1});
      check("mix_count", bus.instr_count, 16'd7);

      run_instr("illegal", 6'b111111, 6'b000000, 2);
      check("illegal_pulse", {sn[1].illegal, sn[2].illegal}, 2'b01);
      check("illegal_count", bus.instr_count, 16'd7);
      run_instr("after_ill", 6'b000000, 6'b100000, 4);
      check("illegal_clear", sn[1].illegal, 1'b0);
      check("after_ill_count", bus.instr_count, 16'd8);

      bus.mem_ready = 1'b0;
      force dut.r_instr_count = 16'hFFFF;
      #1;
      release dut.r_instr_count;
      run_instr("wrap", 6'b000000, 6'b100000, 4);
      check("wrap_count", bus.instr_count, 16'h0000);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
